// File: rtl/cache_read_arb_sm_pkg.sv
// ---------------------------------------------------------------------------
// cache_read_defs
//
// Purpose:
//   Shared definitions for the multi-port cache read state machine and its
//   round-robin arbiter: state encodings, state width, retry counter width
//   and the helper that sizes port-index signals.
//
// Contents:
//   READ_STATE_W   width of the read state (3)
//   read_state_e   READ_IDLE..READ_ERR encodings
//   RETRY_W        width of the per-request refill counter (holds 1..15)
//   port_idx_w()   clog2 of the port count, never less than 1
// ---------------------------------------------------------------------------
package cache_read_defs;

    localparam int READ_STATE_W = 3;

    typedef enum logic [READ_STATE_W-1:0] {
        READ_IDLE  = 3'd0,
        READ_HIT   = 3'd1,
        READ_STALL = 3'd2,
        READ_CHECK = 3'd3,
        READ_ERR   = 3'd4
    } read_state_e;

    localparam int RETRY_W = 4;

    // A single-port build still needs a 1-bit index so port vectors stay legal.
    function automatic int port_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_read_arb_sm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purpose:
//   Purely combinational round-robin selector. Picks the first asserted
//   request at or above the pointer, wrapping around to port 0.
//
// Ports:
//   req_i    [NUM_PORTS-1:0]  request vector
//   ptr_i    [IDX_W-1:0]      highest-priority port this cycle
//   gnt_o    [NUM_PORTS-1:0]  one-hot grant (all zero when nothing requests)
//   idx_o    [IDX_W-1:0]      index of the granted port (0 when none)
//   valid_o                   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import cache_read_defs::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    // Walk the ports starting at the pointer; the first requester found wins.
    always_comb begin
        int                   p;
        logic                 found;
        logic [NUM_PORTS-1:0] gnt;
        logic [IDX_W-1:0]     idx;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        p     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = (int'(ptr_i) + k) % NUM_PORTS;
            if (!found && req_i[p]) begin
                found  = 1'b1;
                gnt[p] = 1'b1;
                idx    = IDX_W'(p);
            end
        end
        gnt_o   = gnt;
        idx_o   = idx;
        valid_o = found;
    end

endmodule

// File: rtl/cache_read_arb_sm.sv
// ---------------------------------------------------------------------------
// cache_read_arb_sm
//
// Purpose:
//   Arbitrates NUM_PORTS read requesters round-robin onto a single tag
//   lookup path. Each granted request is sequenced through hit, or through
//   miss -> refill -> recheck, with at most MAX_RETRY refills before the
//   request is dropped with an error pulse.
//
// Ports:
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   rd_en_i        per-port read request, held with address until served
//   rd_addr_i      packed per-port addresses, port p at [p*ADDR_W +: ADDR_W]
//   lookup_addr_o  combinational address to the tag array
//   hit_i          same-cycle tag match for lookup_addr_o
//   mem_req_o      one-cycle refill request pulse
//   mem_addr_o     refill address, valid while mem_req_o is high
//   mem_done_i     one-cycle refill-complete pulse
//   rd_valid_o     one-hot: data for that port is on the data bus this cycle
//   rd_err_o       one-hot pulse: request dropped after MAX_RETRY refills
//   rd_stall_o     that port's request is in miss handling
//   read_state_o   current state encoding
//   cur_port_o     locked / most recently granted port index
//
// Optional feature (macro CACHE_READ_STATS_EN):
//   clr_stats_i    clears the counters below
//   hit_cnt_o      saturating count of rd_valid pulses
//   miss_cnt_o     saturating count of mem_req pulses
//   err_cnt_o      saturating count of rd_err pulses
// ---------------------------------------------------------------------------
module cache_read_arb_sm
    import cache_read_defs::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_PORTS-1:0]                 rd_en_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]          rd_addr_i,
    output logic [ADDR_W-1:0]                    lookup_addr_o,
    input  logic                                 hit_i,
    output logic                                 mem_req_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    input  logic                                 mem_done_i,
    output logic [NUM_PORTS-1:0]                 rd_valid_o,
    output logic [NUM_PORTS-1:0]                 rd_err_o,
    output logic [NUM_PORTS-1:0]                 rd_stall_o,
    output logic [READ_STATE_W-1:0]              read_state_o,
    output logic [port_idx_w(NUM_PORTS)-1:0]     cur_port_o
`ifdef CACHE_READ_STATS_EN
    ,
    input  logic                                 clr_stats_i,
    output logic [31:0]                          hit_cnt_o,
    output logic [31:0]                          miss_cnt_o,
    output logic [15:0]                          err_cnt_o
`endif
);

    localparam int IDX_W = port_idx_w(NUM_PORTS);

    read_state_e            state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       cur_port_q, cur_port_d;
    logic [RETRY_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [NUM_PORTS-1:0]   rd_valid_q, rd_valid_d;
    logic [NUM_PORTS-1:0]   rd_err_q, rd_err_d;
    logic [NUM_PORTS-1:0]   rd_stall_q, rd_stall_d;

    logic [ADDR_W-1:0]      addr_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]   sel_gnt;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;

    function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_PORTS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_PORTS'(1) << idx;
    endfunction

    // Unpack the flat address bus so ports can be indexed by number.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_arr[p] = rd_addr_i[p*ADDR_W +: ADDR_W];
        end
    end

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req_i   (rd_en_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // Next-state and lookup address. Arbitration only runs in IDLE/HIT; once a
    // miss locks a port, everything follows cur_port until HIT or ERR.
    // rd_valid/rd_err/mem_req are set on the transition so their registered
    // copies line up with the first cycle of the state they belong to.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_port_d    = cur_port_q;
        retry_cnt_d   = retry_cnt_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        rd_valid_d    = '0;
        rd_err_d      = '0;
        rd_stall_d    = rd_stall_q;
        lookup_addr_o = addr_arr[cur_port_q];

        case (state_q)
            READ_IDLE, READ_HIT: begin
                lookup_addr_o = addr_arr[sel_idx];
                if (!sel_valid) begin
                    state_d = READ_IDLE;
                end else begin
                    cur_port_d = sel_idx;
                    if (hit_i) begin
                        state_d    = READ_HIT;
                        rd_valid_d = sel_gnt;
                        rr_ptr_d   = next_port(sel_idx);
                    end else begin
                        state_d     = READ_STALL;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = addr_arr[sel_idx];
                        retry_cnt_d = RETRY_W'(1);
                        rd_stall_d  = sel_gnt;
                    end
                end
            end

            READ_STALL: begin
                if (mem_done_i) begin
                    if (hit_i) begin
                        state_d    = READ_HIT;
                        rd_valid_d = onehot(cur_port_q);
                        rd_stall_d = '0;
                        // Served port drops to lowest priority, as for a direct hit.
                        rr_ptr_d   = next_port(cur_port_q);
                    end else begin
                        state_d = READ_CHECK;
                    end
                end
            end

            READ_CHECK: begin
                if (hit_i) begin
                    state_d    = READ_HIT;
                    rd_valid_d = onehot(cur_port_q);
                    rd_stall_d = '0;
                    rr_ptr_d   = next_port(cur_port_q);
                end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                    state_d     = READ_STALL;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = addr_arr[cur_port_q];
                    retry_cnt_d = retry_cnt_q + 1'b1;
                end else begin
                    state_d    = READ_ERR;
                    rd_err_d   = onehot(cur_port_q);
                    rd_stall_d = '0;
                end
            end

            READ_ERR: begin
                state_d  = READ_IDLE;
                rr_ptr_d = next_port(cur_port_q);
            end

            default: begin
                state_d = READ_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight refill.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= READ_IDLE;
            rr_ptr_q    <= '0;
            cur_port_q  <= '0;
            retry_cnt_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            rd_valid_q  <= '0;
            rd_err_q    <= '0;
            rd_stall_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_port_q  <= cur_port_d;
            retry_cnt_q <= retry_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_stall_q  <= rd_stall_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_err_o     = rd_err_q;
    assign rd_stall_o   = rd_stall_q;
    assign read_state_o = state_q;
    assign cur_port_o   = cur_port_q;

`ifdef CACHE_READ_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [15:0] err_cnt_q;

    // Counters watch the registered output pulses, so each count lands one
    // cycle after the pulse a client sees. Clear has priority over counting.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_stats_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if ((|rd_valid_q) && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (mem_req_q && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            if ((|rd_err_q) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_cache_read_arb_sm.sv
// ---------------------------------------------------------------------------
// tb_cache_read_arb_sm
//
// Bench for cache_read_arb_sm with NUM_PORTS=4, ADDR_W=16, MAX_RETRY=3.
// Inputs change 2 time units after each rising edge; outputs are sampled on
// the falling edge. A request-level model tracks which port owns the lookup
// path and how many refills it has used, and a compare process checks every
// output against it each cycle. Directed sequences add literal expectations.
// Counter checks are included when CACHE_READ_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cache_read_arb_sm;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rstN;
    logic [NP-1:0] rdEn;
    logic [NP*AW-1:0] rdAddr;
    logic          hit;
    logic          memDone;
    logic          clrStats;

    logic [AW-1:0] lookupAddr;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic [NP-1:0] rdValid;
    logic [NP-1:0] rdErr;
    logic [NP-1:0] rdStall;
    logic [2:0]    readState;
    logic [1:0]    curPort;
    logic [31:0]   hitCnt;
    logic [31:0]   missCnt;
    logic [15:0]   errCnt;

    int checks = 0;
    int errors = 0;
    int reqCount = 0;

    always #5 clk = ~clk;

    cache_read_arb_sm #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .MAX_RETRY (MR)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rstN),
        .rd_en_i       (rdEn),
        .rd_addr_i     (rdAddr),
        .lookup_addr_o (lookupAddr),
        .hit_i         (hit),
        .mem_req_o     (memReq),
        .mem_addr_o    (memAddr),
        .mem_done_i    (memDone),
        .rd_valid_o    (rdValid),
        .rd_err_o      (rdErr),
        .rd_stall_o    (rdStall),
        .read_state_o  (readState),
        .cur_port_o    (curPort)
`ifdef CACHE_READ_STATS_EN
        ,
        .clr_stats_i   (clrStats),
        .hit_cnt_o     (hitCnt),
        .miss_cnt_o    (missCnt),
        .err_cnt_o     (errCnt)
`endif
    );

`ifndef CACHE_READ_STATS_EN
    assign hitCnt  = '0;
    assign missCnt = '0;
    assign errCnt  = '0;
`endif

    // ---------------- request-level reference model ----------------
    bit          modelReady = 0;
    int          mPtr, mCur, mRefills;
    bit          mBusy, mAwait, mLastHit, mErrCycle, mReq;
    logic [NP-1:0] mValid, mErr, mStall;
    logic [AW-1:0] mReqAddr;
    int unsigned mHitCnt, mMissCnt, mErrCnt;

    function automatic logic [AW-1:0] addrOf(input int p);
        return rdAddr[p*AW +: AW];
    endfunction

    function automatic int pickPort(input logic [NP-1:0] en, input int ptr);
        for (int k = 0; k < NP; k++) begin
            if (en[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [2:0] expState();
        if (mErrCycle) return 3'd4;
        if (mBusy)     return mAwait ? 3'd2 : 3'd3;
        return mLastHit ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [AW-1:0] expLookup();
        int s;
        if (mBusy || mErrCycle) return addrOf(mCur);
        s = pickPort(rdEn, mPtr);
        return addrOf((s < 0) ? 0 : s);
    endfunction

    always @(posedge clk) begin
        int sel;
        if (!rstN) begin
            mPtr = 0; mCur = 0; mRefills = 0;
            mBusy = 0; mAwait = 0; mLastHit = 0; mErrCycle = 0; mReq = 0;
            mValid = '0; mErr = '0; mStall = '0; mReqAddr = '0;
            mHitCnt = 0; mMissCnt = 0; mErrCnt = 0;
            modelReady = 1;
        end else begin
            if (clrStats) begin
                mHitCnt = 0; mMissCnt = 0; mErrCnt = 0;
            end else begin
                if (mValid != 0) mHitCnt++;
                if (mReq)        mMissCnt++;
                if (mErr != 0)   mErrCnt++;
            end
            mValid = '0; mErr = '0; mReq = 0;
            if (mErrCycle) begin
                mErrCycle = 0;
                mPtr = (mCur + 1) % NP;
                mLastHit = 0;
            end else if (!mBusy) begin
                sel = pickPort(rdEn, mPtr);
                mLastHit = 0;
                if (sel >= 0) begin
                    mCur = sel;
                    if (hit) begin
                        mValid = NP'(1) << sel;
                        mPtr = (sel + 1) % NP;
                        mLastHit = 1;
                    end else begin
                        mBusy = 1; mAwait = 1; mRefills = 1;
                        mReq = 1; mReqAddr = addrOf(sel);
                        mStall = NP'(1) << sel;
                    end
                end
            end else if (mAwait) begin
                if (memDone) begin
                    if (hit) begin
                        mBusy = 0; mAwait = 0; mStall = '0; mLastHit = 1;
                        mValid = NP'(1) << mCur;
                        mPtr = (mCur + 1) % NP;
                    end else begin
                        mAwait = 0;
                    end
                end
            end else begin
                if (hit) begin
                    mBusy = 0; mStall = '0; mLastHit = 1;
                    mValid = NP'(1) << mCur;
                    mPtr = (mCur + 1) % NP;
                end else if (mRefills < MR) begin
                    mRefills++; mAwait = 1; mReq = 1;
                    mReqAddr = addrOf(mCur);
                end else begin
                    mBusy = 0; mStall = '0; mErrCycle = 1;
                    mErr = NP'(1) << mCur;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (memReq === 1'b1) reqCount++;
        if (modelReady) begin
            checkOutput("m_read_state", 32'(readState), 32'(expState()));
            checkOutput("m_rd_valid",   32'(rdValid),   32'(mValid));
            checkOutput("m_rd_err",     32'(rdErr),     32'(mErr));
            checkOutput("m_rd_stall",   32'(rdStall),   32'(mStall));
            checkOutput("m_mem_req",    32'(memReq),    32'(mReq));
            checkOutput("m_cur_port",   32'(curPort),   32'(mCur));
            checkOutput("m_lookup",     32'(lookupAddr), 32'(expLookup()));
            if (mReq) checkOutput("m_mem_addr", 32'(memAddr), 32'(mReqAddr));
`ifdef CACHE_READ_STATS_EN
            checkOutput("m_hit_cnt",  hitCnt,         mHitCnt);
            checkOutput("m_miss_cnt", missCnt,        mMissCnt);
            checkOutput("m_err_cnt",  32'(errCnt),    mErrCnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic driveInputs(input logic [NP-1:0] en, input logic h, input logic done);
        rdEn    = en;
        hit     = h;
        memDone = done;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] en, input logic h, input logic done);
        driveInputs(en, h, done);
        tick();
    endtask

    task automatic setAddr(input int p, input logic [AW-1:0] a);
        rdAddr[p*AW +: AW] = a;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        driveInputs('0, 1'b0, 1'b0);
        tick();
        rstN = 1'b1;
    endtask

    initial begin
        logic [NP-1:0] rrSeq [5];
        int base;
        rrSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rstN = 1'b0; rdEn = '0; rdAddr = '0; hit = 1'b0; memDone = 1'b0; clrStats = 1'b0;
        tick();
        tick();
        checkOutput("reset_state",  32'(readState), 32'd0);
        checkOutput("reset_valid",  32'(rdValid),   32'd0);
        checkOutput("reset_stall",  32'(rdStall),   32'd0);
        checkOutput("reset_memreq", 32'(memReq),    32'd0);
        checkOutput("reset_curport",32'(curPort),   32'd0);
        rstN = 1'b1;

        // Single hit on port 0.
        base = reqCount;
        setAddr(0, 16'h0040);
        driveInputs(4'b0001, 1'b1, 1'b0);
        #1 checkOutput("single_lookup", 32'(lookupAddr), 32'h0040);
        tick();
        checkOutput("single_state", 32'(readState), 32'd1);
        checkOutput("single_valid", 32'(rdValid),   32'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("single_valid_drop", 32'(rdValid),   32'd0);
        checkOutput("single_idle",       32'(readState), 32'd0);
        checkOutput("single_no_memreq",  32'(reqCount - base), 32'd0);

        // Round-robin over four hitting ports from pointer 0.
        doReset();
        setAddr(0, 16'h0100); setAddr(1, 16'h0200); setAddr(2, 16'h0300); setAddr(3, 16'h0400);
        driveInputs(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rr_valid", 32'(rdValid), 32'(rrSeq[i]));
        end
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Miss on port 2, refill completes five cycles later with a hit.
        base = reqCount;
        setAddr(2, 16'h1234);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("miss_state",   32'(readState), 32'd2);
        checkOutput("miss_memreq",  32'(memReq),    32'd1);
        checkOutput("miss_memaddr", 32'(memAddr),   32'h1234);
        checkOutput("miss_stall",   32'(rdStall),   32'b0100);
        checkOutput("miss_curport", 32'(curPort),   32'd2);
        #1 checkOutput("miss_lookup", 32'(lookupAddr), 32'h1234);
        tick();
        checkOutput("miss_req_pulse", 32'(memReq), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(4'b0100, 1'b1, 1'b1);
        checkOutput("refill_valid", 32'(rdValid),   32'b0100);
        checkOutput("refill_stall", 32'(rdStall),   32'd0);
        checkOutput("refill_state", 32'(readState), 32'd1);
        checkOutput("refill_reqs",  32'(reqCount - base), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("refill_idle", 32'(readState), 32'd0);

        // Port 1 never hits: three refills, then an error pulse.
        base = reqCount;
        setAddr(1, 16'hBEEF);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        for (int r = 0; r < MR; r++) begin
            tick();
            applyStimulus(4'b0010, 1'b0, 1'b1);
            checkOutput("retry_check_state", 32'(readState), 32'd3);
            applyStimulus(4'b0010, 1'b0, 1'b0);
            if (r < MR - 1) begin
                checkOutput("retry_restall", 32'(readState), 32'd2);
                checkOutput("retry_memreq",  32'(memReq),    32'd1);
            end else begin
                checkOutput("retry_err_state", 32'(readState), 32'd4);
                checkOutput("retry_err",       32'(rdErr),     32'b0010);
                checkOutput("retry_err_stall", 32'(rdStall),   32'd0);
            end
        end
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("retry_idle",    32'(readState), 32'd0);
        checkOutput("retry_err_end", 32'(rdErr),     32'd0);
        checkOutput("retry_reqs",    32'(reqCount - base), 32'd3);

        // After the error on port 1 the pointer sits at port 2.
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("post_err_ptr", 32'(rdValid), 32'b0100);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Reset during a refill, then a stray mem_done.
        base = reqCount;
        setAddr(3, 16'h0ABC);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("rst_mid_stall", 32'(readState), 32'd2);
        tick();
        rstN = 1'b0;
        tick();
        checkOutput("rst_state",   32'(readState), 32'd0);
        checkOutput("rst_memreq",  32'(memReq),    32'd0);
        checkOutput("rst_stall",   32'(rdStall),   32'd0);
        checkOutput("rst_curport", 32'(curPort),   32'd0);
        rstN = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("stray_done_state", 32'(readState), 32'd0);
        checkOutput("stray_done_valid", 32'(rdValid),   32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("stray_done_reqs", 32'(reqCount - base), 32'd1);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("rst_ptr_zero", 32'(rdValid), 32'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b0);

`ifdef CACHE_READ_STATS_EN
        // Three hits plus one refilled miss, then clear.
        doReset();
        driveInputs(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        setAddr(2, 16'h1234);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b1, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("stats_hit",  hitCnt,       32'd4);
        checkOutput("stats_miss", missCnt,      32'd1);
        checkOutput("stats_err",  32'(errCnt),  32'd0);
        clrStats = 1'b1;
        tick();
        clrStats = 1'b0;
        checkOutput("stats_clr_hit",  hitCnt,  32'd0);
        checkOutput("stats_clr_miss", missCnt, 32'd0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_read_arb_sm.md
Name: cache_read_arb_sm

Overview:
Multi-port successor to the single-requester cache read state machine. Arbitrates NUM_PORTS read requesters round-robin onto one tag-lookup path, sequences hit/miss/refill/recheck per request, issues refill requests to memory, and bounds refill retries with an error return. Sits between the rasterizer's texture/depth read clients and the cache tag/data arrays plus memory fill engine.

Parameters:
NUM_PORTS, 4, number of requester channels (1..8)
ADDR_W, 16, read address width
MAX_RETRY, 3, refills allowed per request before error (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
rd_en  in  NUM_PORTS  per-port read request; held with rd_addr until rd_valid or rd_err for that port
rd_addr  in  NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
lookup_addr  out  ADDR_W  combinational address to tag array
hit  in  1  combinational tag-match result for lookup_addr, same cycle
mem_req  out  1  one-cycle refill request pulse
mem_addr  out  ADDR_W  refill address, valid while mem_req is high
mem_done  in  1  one-cycle refill-complete pulse
rd_valid  out  NUM_PORTS  one-hot registered: data for that port is on the cache data bus this cycle
rd_err  out  NUM_PORTS  one-hot registered pulse: request dropped after MAX_RETRY refills
rd_stall  out  NUM_PORTS  registered: that port's request is in miss handling
read_state  out  3  current state
cur_port  out  clog2(NUM_PORTS), min 1  locked/selected port index

Behaviour:
- States (3-bit): IDLE=0, HIT=1, STALL=2, CHECK=3, ERR=4; all other encodings -> IDLE next cycle.
- Reset (rst_n low at posedge): read_state=IDLE, rr_ptr=0, retry_cnt=0, cur_port=0, mem_req=0, rd_valid=0, rd_err=0, rd_stall=0. Reset overrides everything, including mid-refill. A late mem_done arriving after reset is ignored.
- Arbitration in IDLE/HIT: sel = first p with rd_en[p], searching from rr_ptr upward with wrap-around; lookup_addr = rd_addr[sel] (port 0 when none pending).
- IDLE/HIT transitions:
  - No request -> IDLE.
  - Request and hit -> HIT; rd_valid[sel]=1 next cycle (1-cycle latency); rr_ptr=sel+1 mod NUM_PORTS.
  - Request and miss -> STALL; cur_port=sel locked; mem_req=1 and mem_addr=rd_addr[sel] for exactly the entry cycle; retry_cnt=1; rd_stall[sel]=1.
- A port served in HIT drops or changes rd_en in the same cycle rd_valid is seen. Back-to-back hits on different ports sustain one rd_valid per cycle.
- STALL: lookup_addr=rd_addr[cur_port]. Stays until mem_done; then CHECK if ~hit, or HIT if hit (rd_valid[cur_port] next, rd_stall cleared). Arbitration is frozen.
- CHECK: lookup_addr=rd_addr[cur_port].
  - hit -> HIT with rd_valid[cur_port].
  - miss and retry_cnt<MAX_RETRY -> STALL; mem_req pulses again; retry_cnt+1.
  - miss and retry_cnt==MAX_RETRY -> ERR.
- ERR: rd_err[cur_port]=1 for one cycle, rd_stall cleared, rr_ptr=cur_port+1, next state IDLE.
- rd_en drop on the locked port during STALL/CHECK: protocol violation. The request still completes and the result is discarded by the client.
- mem_done outside STALL is ignored. mem_req is never issued while a refill is outstanding.
- HIT rr_ptr and rd_valid update apply in the same cycle as the next selection.

Optional Feature:
CACHE_READ_STATS_EN. When defined, adds outputs:
- hit_cnt[31:0]: increments on each rd_valid.
- miss_cnt[31:0]: increments on each mem_req.
- err_cnt[15:0]: increments on each rd_err.
All counters saturate, reset to 0 and clear on clr_stats (input, 1). When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header cache_read_defs: state encodings READ_IDLE..READ_ERR, state width 3, port-index width function.
- One sub-module rr_arbiter (NUM_PORTS request vector plus pointer -> one-hot grant and index, combinational). The FSM stays in the top.

Test Plan:
- Single hit: rd_en=4'b0001, addr 0x0040, hit=1 -> read_state=HIT next cycle, rd_valid=4'b0001 for 1 cycle, mem_req never asserted.
- Round-robin: rd_en=4'b1111, all hit, held -> rd_valid sequence 0001,0010,0100,1000,0001 on consecutive cycles.
- Miss then refill: port 2 addr 0x1234 miss -> mem_req 1 cycle with mem_addr=0x1234, rd_stall=4'b0100; mem_done after 5 cycles with hit=1 -> rd_valid=4'b0100 next cycle, rd_stall=0.
- Retry exhaustion: MAX_RETRY=3, hit tied 0 on port 1 -> exactly 3 mem_req pulses, one per mem_done, then rd_err=4'b0010 one cycle, state IDLE.
- Reset mid-STALL: rst_n low for 1 cycle while STALL -> all outputs 0, state IDLE; subsequent stray mem_done causes no transition.
- Stats (CACHE_READ_STATS_EN): 3 hits, 1 miss refilled -> hit_cnt=4, miss_cnt=1, err_cnt=0; clr_stats -> all 0.
